// File: rtl/pipeline_ctrl.sv
// Stall/bubble controller for the 5-stage pipeline: load-use, M-stage jump flush
// and memory freeze, plus a wait-state FSM, sticky timeout and perf counters.
module pipeline_ctrl #(
    parameter int MAX_WAIT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic        d_use_rs,
    input  logic        d_use_rt,
    input  logic        e_wreg,
    input  logic        e_m2reg,
    input  logic [4:0]  e_rn,
    input  logic        m_do_jmp,
    input  logic        m_mem_req,
    input  logic        m_mem_ready,
    output logic        f_stall,
    output logic        d_stall,
    output logic        e_stall,
    output logic        m_stall,
    output logic        d_bubble,
    output logic        e_bubble,
    output logic        m_bubble,
    output logic        w_bubble,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
);

    localparam int            CW   = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t        state_q;
    logic [CW-1:0] wait_cnt_q;
    logic          mem_timeout_q;
    logic [31:0]   stall_cycles_q, stall_cycles_d;
    logic [15:0]   flush_count_q,  flush_count_d;

    logic mem_hold, jmp, lu, rs_hit, rt_hit;

    always_comb begin
        mem_hold = m_mem_req & ~m_mem_ready;
        jmp      = m_do_jmp & ~mem_hold;
        rs_hit   = d_use_rs & (d_rs == e_rn);
        rt_hit   = d_use_rt & (d_rt == e_rn);
        lu       = e_wreg & e_m2reg & (e_rn != 5'd0) & (rs_hit | rt_hit) & ~mem_hold & ~jmp;
    end

    // Outputs are forced quiet while reset is held, independent of the inputs.
    always_comb begin
        f_stall  = ~reset & (mem_hold | lu);
        d_stall  = ~reset & (mem_hold | lu);
        e_stall  = ~reset & mem_hold;
        m_stall  = ~reset & mem_hold;
        d_bubble = ~reset & jmp;
        e_bubble = ~reset & (jmp | lu);
        m_bubble = ~reset & jmp;
        w_bubble = ~reset & mem_hold;
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (f_stall && stall_cycles_q != 32'hFFFF_FFFF)
            stall_cycles_d = stall_cycles_q + 32'd1;
        if (jmp && flush_count_q != 16'hFFFF)
            flush_count_d = flush_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            if (mem_hold && wait_cnt_q == WMAX)
                mem_timeout_q <= 1'b1;
            case (state_q)
                RUN: begin
                    if (mem_hold) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= CW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_hold) begin
                        if (wait_cnt_q != WMAX)
                            wait_cnt_q <= wait_cnt_q + CW'(1);
                    end else begin
                        state_q    <= RUN;
                        wait_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    wait_cnt_q <= '0;
                end
            endcase
        end
    end

    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule
